// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back and a buffered MDU result FIFO.
// Writes land one cycle after grant; MDU is backpressured via o_mdu_ready, pipeline via o_wb_stall in DRAIN.
module wb_port_arbiter #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_wb_valid,
  input  logic                           i_wb_reg_write,
  input  logic [4:0]                     i_wb_rd,
  input  logic [XLEN-1:0]                i_wb_data,
  output logic                           o_wb_stall,
  input  logic                           i_mdu_valid,
  input  logic [4:0]                     i_mdu_rd,
  input  logic [XLEN-1:0]                i_mdu_data,
  output logic                           o_mdu_ready,
  output logic                           o_rf_we,
  output logic [4:0]                     o_rf_rd,
  output logic [XLEN-1:0]                o_rf_wdata,
  output logic [$clog2(BUF_DEPTH+1)-1:0] o_buf_count
);
  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int WW = $clog2(MAX_WAIT+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state, state_nx;
  logic [CW-1:0]   count, count_nx;
  logic [WW-1:0]   wait_cnt, wait_nx;
  logic [4:0]      buf_rd      [BUF_DEPTH];
  logic [XLEN-1:0] buf_data    [BUF_DEPTH];
  logic [4:0]      buf_rd_nx   [BUF_DEPTH];
  logic [XLEN-1:0] buf_data_nx [BUF_DEPTH];

  logic pipe_req, grant_pipe, grant_buf, enq, head_sq;

  assign pipe_req    = i_wb_valid & i_wb_reg_write & (i_wb_rd != 5'd0);
  assign o_mdu_ready = (count < CW'(BUF_DEPTH)) & (state != DRAIN);
  assign enq         = i_mdu_valid & o_mdu_ready & (i_mdu_rd != 5'd0);
  assign grant_pipe  = pipe_req & (state != DRAIN);
  assign grant_buf   = ~grant_pipe & (count != '0);
  assign head_sq     = grant_pipe & (count != '0) & (buf_rd[0] == i_wb_rd);
  assign o_wb_stall  = (state == DRAIN) & pipe_req;
  assign o_buf_count = count;

  // Rebuild the FIFO: drop the popped head and any entry shadowed by the
  // granted pipeline write (it is younger), then append the new MDU result.
  always_comb begin
    int  n;
    logic keep;
    buf_rd_nx   = buf_rd;
    buf_data_nx = buf_data;
    n           = 0;
    keep        = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      keep = (i < int'(count)) && !(grant_buf && i == 0) &&
             !(grant_pipe && buf_rd[i] == i_wb_rd);
      for (int j = 0; j < BUF_DEPTH; j++) begin
        if (keep && j == n) begin
          buf_rd_nx[j]   = buf_rd[i];
          buf_data_nx[j] = buf_data[i];
        end
      end
      if (keep) n++;
    end
    keep = enq && !(grant_pipe && i_mdu_rd == i_wb_rd);
    for (int j = 0; j < BUF_DEPTH; j++) begin
      if (keep && j == n) begin
        buf_rd_nx[j]   = i_mdu_rd;
        buf_data_nx[j] = i_mdu_data;
      end
    end
    if (keep) n++;
    count_nx = CW'(n);
  end

  // A head replaced by pop or squash starts its wait from zero.
  always_comb begin
    if (count_nx == '0 || grant_buf || head_sq)
      wait_nx = '0;
    else if (count != '0 && wait_cnt != WW'(MAX_WAIT))
      wait_nx = wait_cnt + WW'(1);
    else
      wait_nx = wait_cnt;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count_nx != '0) state_nx = PEND;
      PEND: begin
        if (count_nx == '0)
          state_nx = IDLE;
        else if (count_nx == CW'(BUF_DEPTH) || wait_nx == WW'(MAX_WAIT))
          state_nx = DRAIN;
      end
      DRAIN:   if (count_nx == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      count      <= '0;
      wait_cnt   <= '0;
      o_rf_we    <= 1'b0;
      o_rf_rd    <= 5'd0;
      o_rf_wdata <= '0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      wait_cnt <= wait_nx;
      if (grant_pipe) begin
        o_rf_we    <= 1'b1;
        o_rf_rd    <= i_wb_rd;
        o_rf_wdata <= i_wb_data;
      end else if (grant_buf) begin
        o_rf_we    <= 1'b1;
        o_rf_rd    <= buf_rd[0];
        o_rf_wdata <= buf_data[0];
      end else begin
        o_rf_we    <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; count alone marks valid entries.
  always_ff @(posedge i_clk) begin
    buf_rd   <= buf_rd_nx;
    buf_data <= buf_data_nx;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between the in-order pipeline write-back stream (WriteBack output) and a long-latency multiply/divide unit (MDU). MDU results are queued in a small buffer. The pipeline has priority until the buffer fills or an entry waits too long; then the arbiter stalls the pipeline and drains the buffer. Sits between WriteBack/MDU and the register file.

Parameters:
XLEN, 32, data width
BUF_DEPTH, 2, MDU result buffer entries (≥1)
MAX_WAIT, 4, cycles a buffered head entry may be denied before a forced drain (≥1)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_wb_valid  in  1  pipeline write-back slot valid
i_wb_reg_write  in  1  pipeline instruction writes rd
i_wb_rd  in  5  pipeline destination register
i_wb_data  in  XLEN  pipeline write data (o_wb_data of WriteBack)
o_wb_stall  out  1  pipeline must hold its WB inputs this cycle
i_mdu_valid  in  1  MDU result valid
i_mdu_rd  in  5  MDU destination register
i_mdu_data  in  XLEN  MDU result
o_mdu_ready  out  1  arbiter accepts MDU result this cycle
o_rf_we  out  1  register-file write enable (registered)
o_rf_rd  out  5  register-file write address (registered)
o_rf_wdata  out  XLEN  register-file write data (registered)
o_buf_count  out  $clog2(BUF_DEPTH+1)  buffered MDU entries

Behaviour:
- Reset (async, i_rst_n=0): o_rf_we=0, o_rf_rd=0, o_rf_wdata=0, buffer empty, wait counter 0, state IDLE. Reset mid-operation discards buffered entries; no write is issued for them.
- pipe_req = i_wb_valid & i_wb_reg_write & (i_wb_rd!=0). A non-writing or x0 slot never conflicts and never stalls.
- MDU handshake: o_mdu_ready = (count<BUF_DEPTH) & (state!=DRAIN), from registered state only. Enqueue on i_mdu_valid&o_mdu_ready. rd=0 completes the handshake but is discarded.
- No bypass: an enqueued entry is grantable the next cycle at the earliest. MDU handshake to o_rf_we takes ≥2 cycles.
- States:
  - IDLE: count=0.
  - PEND: count>0, pipeline has priority.
  - DRAIN: buffer has priority.
- Grant, IDLE/PEND: pipe_req → pipeline is granted, o_wb_stall=0. Otherwise, if count>0 → buffer head is granted and popped.
- Grant, DRAIN: buffer head is granted and popped. o_wb_stall = pipe_req (combinational). The pipeline write is not performed and must be re-presented.
- Transitions, evaluated on next-state count/wait:
  - IDLE→PEND when an entry is enqueued.
  - PEND→DRAIN when count==BUF_DEPTH or wait==MAX_WAIT.
  - PEND→IDLE when count reaches 0.
  - DRAIN→IDLE when count reaches 0. DRAIN exits only to IDLE.
- Wait counter:
  - Increments each cycle count>0 and the head is not popped.
  - Clears on any pop or when empty.
  - Saturates at MAX_WAIT.
- Output latency: a grant in cycle N drives o_rf_we=1 with its rd/data in cycle N+1. With no grant, o_rf_we=0 and o_rf_rd/o_rf_wdata hold their values.
- WAW squash: a granted pipeline write to rd R drops every buffered entry with rd R, compacting the FIFO in order. It also drops an MDU result with rd R enqueued that same cycle; the handshake still completes. The MDU result is older, so the pipeline value must survive.
- Simultaneous pop and enqueue: allowed when count<BUF_DEPTH; count is unchanged.
- Buffer order: FIFO; entries are written in arrival order.

Test Plan:
- Pipeline only: valid=1, reg_write=1, rd=5, data=AAAAAAAA for 1 cycle → next cycle o_rf_we=1, rd=5, wdata=AAAAAAAA; o_wb_stall never asserts. rd=0 or reg_write=0 → o_rf_we stays 0.
- MDU into idle pipeline: MDU rd=7, data=BBBBBBBB handshakes in cycle 0 → grant in cycle 1; o_rf_we=1, rd=7 in cycle 2; o_buf_count returns to 0.
- Priority and forced drain: pipeline writes every cycle (rd=1..); MDU enqueues rd=9 → pipeline keeps winning. After MAX_WAIT=4 denied cycles the state enters DRAIN: o_wb_stall=1 for one cycle and rd=9 is written next cycle. Pipeline data presented during the stall is written after it.
- Buffer full: MDU enqueues rd=10, then rd=11 while pipeline is busy → count=2, o_mdu_ready=0, DRAIN. Writes are rd=10 then rd=11, in order, with stall asserted 2 cycles; then IDLE and ready=1.
- WAW squash: buffer holds rd=12 data=11111111; pipeline grants rd=12 data=22222222 → only 22222222 is written to x12; count drops to 0 with no MDU write.
- Reset mid-operation: count=2, then i_rst_n=0 asynchronously → o_rf_we=0 immediately, count=0. After release, no stale entry is ever written.
